uart_dm_loader: RTL and testbench
=================================

// Module: uart_dm_loader
// PURPOSE
//  UART protocol controller that feeds the core's external data-memory port (con_write/con_addr/con_in/con_out).
//  Host sends byte commands over 8N1 serial; block performs word writes/reads on DATAMEM and replies over tx.
//  Sits outside the core at top level; sole driver of the con_* inputs of the core.
// PARAMETERS
//  CLKS_PER_BIT    434        CLK cycles per UART bit (50 MHz / 115200)
//  TIMEOUT_CYCLES  1_000_000  max CLK cycles between bytes of one command before abort
// PORTS
//  CLK        in   1   system clock, all logic on rising edge
//  nrst       in   1   asynchronous active-low reset
//  rx         in   1   UART receive line, idle high, asynchronous to CLK
//  tx         out  1   UART transmit line, idle high
//  con_write  out  4   byte write enables to DATAMEM; 4'hF for one cycle per write, else 0
//  con_addr   out  10  DATAMEM word address
//  con_in     out  32  DATAMEM write data
//  con_out    in   32  DATAMEM read data, valid one CLK after con_addr changes
//  busy       out  1   high whenever FSM is not in IDLE
//  err        out  1   one-cycle pulse on framing/parity error or inter-byte timeout
// BEHAVIOUR
//  Reset: tx=1, con_write=0, con_addr=0, con_in=0, busy=0, err=0, FSM=IDLE, all counters 0.
//  RX: rx through 2-flop synchroniser; falling edge starts frame; start re-sampled at CLKS_PER_BIT/2,
//   high there = false start, discard silently; data sampled mid-bit, LSB first; stop bit 0 = framing error:
//   byte dropped, err pulse, FSM -> IDLE. rx_valid pulses 1 cycle with rx_byte at middle of stop bit.
//  TX: 8N1 LSB first; start request accepted only when TX idle; one byte in flight, no queue.
//  Command FSM states: IDLE, ADDR_HI, ADDR_LO, DATA, WRITE, RD_REQ, RD_WAIT, TX_RESP.
//   IDLE: 0x57 'W' -> ADDR_HI(wr); 0x52 'R' -> ADDR_HI(rd); any other byte -> transmit 0x3F '?', stay IDLE.
//   ADDR_HI: byte[1:0] -> addr[9:8], byte[7:2] ignored. ADDR_LO: byte -> addr[7:0]; wr -> DATA, rd -> RD_REQ.
//   DATA: 4 bytes, little-endian into con_in (byte0 -> [7:0]); 2-bit counter; after 4th -> WRITE.
//   WRITE: con_addr/con_in stable, con_write=4'hF exactly one cycle; then send 0x4B 'K' -> IDLE.
//   RD_REQ: drive con_addr, 1 cycle; RD_WAIT: latch con_out into 32-bit shift reg -> TX_RESP.
//   TX_RESP: send 4 bytes LSB byte first, back-to-back; after last stop bit -> IDLE.
//  con_addr/con_in hold last value outside transactions. Only WRITE asserts con_write.
//  Bytes received in WRITE/RD_*/TX_RESP, or while 'K'/'?' still transmitting, are dropped, no err.
//  Timeout: in ADDR_HI/ADDR_LO/DATA, counter resets per byte; reaching TIMEOUT_CYCLES -> err pulse, IDLE, no tx.
//  Simultaneous rx error and timeout in same cycle: single err pulse.
//  nrst low mid-command or mid-byte: immediate return to reset state; partial command lost, no write issued,
//   tx forced high (receiver sees truncated frame).
// CONFIGURATION
//  UART_PARITY_EN defined: frames are 8E1 on rx and tx (even parity bit after bit 7, before stop);
//   rx parity mismatch treated as framing error (byte dropped, err pulse, IDLE).
//  Undefined: 8N1 only, no parity bit, parity logic absent.
// STRUCTURE
//  Shared package uart_dm_pkg: state enum, command constants CMD_WR=8'h57, CMD_RD=8'h52,
//   RSP_ACK=8'h4B, RSP_NAK=8'h3F.
//  One sub-module: uart_rx (synchroniser, bit timing, framing/parity check -> rx_valid/rx_byte/rx_err).
//  TX serializer and command FSM inline in uart_dm_loader.
// TESTING
//  Write: 57 00 05 78 56 34 12 -> one cycle con_write=F, con_addr=0x005, con_in=0x12345678; tx 0x4B.
//  Read: 52 03 FF, memory model con_out=0xDEADBEEF at 0x3FF -> tx EF BE AD DE, busy low after.
//  Unknown command 41 -> tx 0x3F, con_write never asserted, FSM stays IDLE.
//  Timeout: 57 00 then idle > TIMEOUT_CYCLES -> single err pulse, IDLE; following valid write succeeds.
//  Framing error: byte with stop bit 0 during DATA -> err pulse, no write, no tx; next command OK.
//  Reset mid-DATA (after 2 data bytes) -> outputs at reset values, con_write stays 0; with UART_PARITY_EN,
//   bad-parity byte -> err pulse and drop.

Source files
------------

// File: rtl/uart_dm_pkg.sv
// Shared types and constants for the UART data-memory loader.
// UART_PARITY_EN selects 8E1 framing on rx and tx instead of 8N1.
package uart_dm_pkg;

  typedef enum logic [2:0] {
    StIdle, StAddrHi, StAddrLo, StData, StWrite, StRdReq, StRdWait, StTxResp
  } cmd_state_e;

  typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxParity, RxStop} rx_state_e;

  localparam logic [7:0] CMD_WR  = 8'h57;
  localparam logic [7:0] CMD_RD  = 8'h52;
  localparam logic [7:0] RSP_ACK = 8'h4B;
  localparam logic [7:0] RSP_NAK = 8'h3F;

`ifdef UART_PARITY_EN
  localparam int unsigned FrameBits = 11;
`else
  localparam int unsigned FrameBits = 10;
`endif

  // Full serial frame, bit 0 is the start bit.
  function automatic logic [FrameBits-1:0] tx_frame(input logic [7:0] b);
`ifdef UART_PARITY_EN
    return {1'b1, ^b, b, 1'b0};
`else
    return {1'b1, b, 1'b0};
`endif
  endfunction

endpackage

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchroniser, mid-bit sampling, framing (and optional parity) check.
// UART_PARITY_EN adds an even parity bit between bit 7 and the stop bit.
module uart_rx
  import uart_dm_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rx_i,
  output logic       rx_valid_o,
  output logic [7:0] rx_byte_o,
  output logic       rx_err_o
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] BitEnd  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] HalfEnd = CntW'(CLKS_PER_BIT / 2 - 1);

  rx_state_e       state_q;
  logic            rx_meta_q, rx_sync_q, rx_prev_q;
  logic [CntW-1:0] cnt_q;
  logic [2:0]      bit_q;
  logic [7:0]      shift_q;
  logic            bit_end, frame_ok;

  assign bit_end = (cnt_q == BitEnd);

`ifdef UART_PARITY_EN
  logic par_bad_q;
  assign frame_ok = rx_sync_q & ~par_bad_q;
`else
  assign frame_ok = rx_sync_q;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= RxIdle;
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      rx_valid_o <= 1'b0;
      rx_byte_o  <= '0;
      rx_err_o   <= 1'b0;
`ifdef UART_PARITY_EN
      par_bad_q  <= 1'b0;
`endif
    end else begin
      rx_meta_q  <= rx_i;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      rx_valid_o <= 1'b0;
      rx_err_o   <= 1'b0;
      unique case (state_q)
        RxIdle: begin
          if (rx_prev_q && !rx_sync_q) begin
            state_q <= RxStart;
            cnt_q   <= '0;
          end
        end
        RxStart: begin
          if (cnt_q == HalfEnd) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            // A line that is high again by mid-start was a glitch.
            state_q <= rx_sync_q ? RxIdle : RxData;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RxData: begin
          if (bit_end) begin
            cnt_q   <= '0;
            shift_q <= {rx_sync_q, shift_q[7:1]};
            bit_q   <= bit_q + 3'd1;
            if (bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
              state_q <= RxParity;
`else
              state_q <= RxStop;
`endif
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
`ifdef UART_PARITY_EN
        RxParity: begin
          if (bit_end) begin
            cnt_q     <= '0;
            par_bad_q <= rx_sync_q ^ (^shift_q);
            state_q   <= RxStop;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
`endif
        RxStop: begin
          if (bit_end) begin
            state_q <= RxIdle;
            if (frame_ok) begin
              rx_valid_o <= 1'b1;
              rx_byte_o  <= shift_q;
            end else begin
              rx_err_o <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= RxIdle;
      endcase
    end
  end

endmodule

// File: rtl/uart_dm_loader.sv
// UART command controller driving the core's external data-memory port (word write/read).
// UART_PARITY_EN switches rx and tx framing from 8N1 to 8E1.
module uart_dm_loader
  import uart_dm_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT   = 434,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        CLK,
  input  logic        nrst,
  input  logic        rx,
  output logic        tx,
  output logic [3:0]  con_write,
  output logic [9:0]  con_addr,
  output logic [31:0] con_in,
  input  logic [31:0] con_out,
  output logic        busy,
  output logic        err
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam int unsigned ToW  = $clog2(TIMEOUT_CYCLES);
  localparam logic [CntW-1:0] BitEnd = CntW'(CLKS_PER_BIT - 1);
  localparam logic [ToW-1:0]  ToEnd  = ToW'(TIMEOUT_CYCLES - 1);

  logic       rx_valid, rx_err;
  logic [7:0] rx_byte;

  cmd_state_e     state_q;
  logic           is_wr_q;
  logic [9:0]     addr_q;
  logic [23:0]    data_q;
  logic [1:0]     byte_cnt_q;
  logic [ToW-1:0] to_cnt_q;
  logic [31:0]    resp_q;
  logic [2:0]     resp_cnt_q;
  logic [3:0]     con_write_q;
  logic [9:0]     con_addr_q;
  logic [31:0]    con_in_q;
  logic           err_q;

  logic [FrameBits-1:0] tx_shift_q;
  logic                 tx_busy_q;
  logic [CntW-1:0]      tx_cnt_q;
  logic [3:0]           tx_left_q;

  logic       collecting, timeout, rx_err_seen, tx_req;
  logic [7:0] tx_data;

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk_i     (CLK),
    .rst_ni    (nrst),
    .rx_i      (rx),
    .rx_valid_o(rx_valid),
    .rx_byte_o (rx_byte),
    .rx_err_o  (rx_err)
  );

  always_comb begin
    collecting  = state_q inside {StAddrHi, StAddrLo, StData};
    timeout     = collecting && (to_cnt_q == ToEnd);
    // Errors during write/read/response phases are ignored like any other byte there.
    rx_err_seen = rx_err && (collecting || state_q == StIdle);
    tx_req      = 1'b0;
    tx_data     = RSP_ACK;
    unique case (state_q)
      StIdle: begin
        if (rx_valid && !tx_busy_q && rx_byte != CMD_WR && rx_byte != CMD_RD) begin
          tx_req  = 1'b1;
          tx_data = RSP_NAK;
        end
      end
      StWrite: tx_req = 1'b1;
      StTxResp: begin
        if (!tx_busy_q && resp_cnt_q != 3'd4) begin
          tx_req  = 1'b1;
          tx_data = resp_q[7:0];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge nrst) begin
    if (!nrst) begin
      state_q     <= StIdle;
      is_wr_q     <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      byte_cnt_q  <= '0;
      to_cnt_q    <= '0;
      resp_q      <= '0;
      resp_cnt_q  <= '0;
      con_write_q <= '0;
      con_addr_q  <= '0;
      con_in_q    <= '0;
      err_q       <= 1'b0;
      tx_shift_q  <= '1;
      tx_busy_q   <= 1'b0;
      tx_cnt_q    <= '0;
      tx_left_q   <= '0;
    end else begin
      con_write_q <= '0;
      err_q       <= timeout || rx_err_seen;

      if (tx_req) begin
        tx_shift_q <= tx_frame(tx_data);
        tx_busy_q  <= 1'b1;
        tx_cnt_q   <= '0;
        tx_left_q  <= 4'(FrameBits);
      end else if (tx_busy_q) begin
        if (tx_cnt_q == BitEnd) begin
          tx_cnt_q <= '0;
          if (tx_left_q == 4'd1) begin
            tx_busy_q  <= 1'b0;
            tx_shift_q <= '1;
          end else begin
            tx_shift_q <= {1'b1, tx_shift_q[FrameBits-1:1]};
            tx_left_q  <= tx_left_q - 4'd1;
          end
        end else begin
          tx_cnt_q <= tx_cnt_q + 1'b1;
        end
      end

      if (collecting) to_cnt_q <= rx_valid ? '0 : to_cnt_q + 1'b1;

      unique case (state_q)
        StIdle: begin
          if (rx_valid && !tx_busy_q && (rx_byte == CMD_WR || rx_byte == CMD_RD)) begin
            is_wr_q  <= (rx_byte == CMD_WR);
            to_cnt_q <= '0;
            state_q  <= StAddrHi;
          end
        end
        StAddrHi: begin
          if (timeout || rx_err) begin
            state_q <= StIdle;
          end else if (rx_valid) begin
            addr_q[9:8] <= rx_byte[1:0];
            state_q     <= StAddrLo;
          end
        end
        StAddrLo: begin
          if (timeout || rx_err) begin
            state_q <= StIdle;
          end else if (rx_valid) begin
            addr_q[7:0] <= rx_byte;
            byte_cnt_q  <= '0;
            if (is_wr_q) begin
              state_q <= StData;
            end else begin
              con_addr_q <= {addr_q[9:8], rx_byte};
              state_q    <= StRdReq;
            end
          end
        end
        StData: begin
          if (timeout || rx_err) begin
            state_q <= StIdle;
          end else if (rx_valid) begin
            byte_cnt_q <= byte_cnt_q + 2'd1;
            unique case (byte_cnt_q)
              2'd0: data_q[7:0]   <= rx_byte;
              2'd1: data_q[15:8]  <= rx_byte;
              2'd2: data_q[23:16] <= rx_byte;
              default: begin
                con_in_q    <= {rx_byte, data_q};
                con_addr_q  <= addr_q;
                con_write_q <= 4'hF;
                state_q     <= StWrite;
              end
            endcase
          end
        end
        StWrite:  state_q <= StIdle;
        StRdReq:  state_q <= StRdWait;
        StRdWait: begin
          resp_q     <= con_out;
          resp_cnt_q <= '0;
          state_q    <= StTxResp;
        end
        StTxResp: begin
          if (!tx_busy_q) begin
            if (resp_cnt_q == 3'd4) begin
              state_q <= StIdle;
            end else begin
              resp_q     <= {8'h00, resp_q[31:8]};
              resp_cnt_q <= resp_cnt_q + 3'd1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign tx        = tx_shift_q[0];
  assign con_write = con_write_q;
  assign con_addr  = con_addr_q;
  assign con_in    = con_in_q;
  assign busy      = (state_q != StIdle);
  assign err       = err_q;

endmodule

// File: tb/tb_uart_dm_loader.sv
// Self-checking bench for uart_dm_loader: serial host driver, tx decoder, memory model.
module tb_uart_dm_loader;

  localparam int unsigned CPB = 8;
  localparam int unsigned TO  = 3000;

  logic        CLK = 1'b0;
  logic        nrst;
  logic        rx;
  logic        tx;
  logic [3:0]  con_write;
  logic [9:0]  con_addr;
  logic [31:0] con_in;
  logic [31:0] con_out;
  logic        busy;
  logic        err;

  int checks   = 0;
  int failures = 0;
  int err_cnt  = 0;
  int tx_bad   = 0;

  logic [31:0] mem     [1024];
  logic [31:0] exp_mem [1024];
  logic [45:0] wr_q[$];
  logic [7:0]  txq[$];
  logic [9:0]  written[$];

  always #5 CLK = ~CLK;

  uart_dm_loader #(
    .CLKS_PER_BIT  (CPB),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .CLK      (CLK),
    .nrst     (nrst),
    .rx       (rx),
    .tx       (tx),
    .con_write(con_write),
    .con_addr (con_addr),
    .con_in   (con_in),
    .con_out  (con_out),
    .busy     (busy),
    .err      (err)
  );

  // Synchronous memory: read data valid one clock after the address.
  always @(posedge CLK) begin
    if (con_write == 4'hF) mem[con_addr] <= con_in;
    con_out <= mem[con_addr];
  end

  always @(negedge CLK) begin
    if (nrst === 1'b1 && con_write !== 4'h0) wr_q.push_back({con_write, con_addr, con_in});
    if (err === 1'b1) err_cnt++;
  end

  // Host-side decoder of the tx line.
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge tx);
      repeat (CPB / 2) @(negedge CLK);
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge CLK);
        b[i] = tx;
      end
`ifdef UART_PARITY_EN
      repeat (CPB) @(negedge CLK);
      if (tx !== ^b) tx_bad++;
`endif
      repeat (CPB) @(negedge CLK);
      if (tx !== 1'b1) tx_bad++;
      txq.push_back(b);
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // kind: 0 good frame, 1 stop bit low, 2 wrong parity bit
  task automatic send_byte(input logic [7:0] b, input int kind);
    rx = 1'b0;
    repeat (CPB) @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge CLK);
    end
`ifdef UART_PARITY_EN
    rx = (^b) ^ (kind == 2);
    repeat (CPB) @(negedge CLK);
`endif
    rx = (kind != 1);
    repeat (CPB) @(negedge CLK);
    rx = 1'b1;
    repeat (2) @(negedge CLK);
  endtask

  task automatic send_write(input logic [9:0] a, input logic [31:0] d);
    send_byte(8'h57, 0);
    send_byte({6'($urandom), a[9:8]}, 0);
    send_byte(a[7:0], 0);
    for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8], 0);
  endtask

  task automatic wait_tx(input int n, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 40 * CPB * (n + 1); c++) begin
      if (txq.size() >= n) begin
        ok = 1'b1;
        break;
      end
      @(negedge CLK);
    end
    repeat (2 * CPB) @(negedge CLK);
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    rx   = 1'b1;
    repeat (3) @(negedge CLK);
    nrst = 1'b1;
    @(negedge CLK);
    checks++; if (tx !== 1'b1) begin failures++; $display("FAIL reset_tx: got %b want 1", tx); end
    checks++; if (con_write !== 4'h0) begin failures++; $display("FAIL reset_we: got %h want 0", con_write); end
    checks++; if (con_addr !== 10'h0) begin failures++; $display("FAIL reset_addr: got %h want 0", con_addr); end
    checks++; if (con_in !== 32'h0) begin failures++; $display("FAIL reset_din: got %h want 0", con_in); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b want 0", err); end
  endtask

  task automatic test_write();
    for (int it = 0; it < 5; it++) begin
      logic [9:0]  a;
      logic [31:0] d;
      logic [45:0] w;
      logic [7:0]  r;
      bit ok;
      a = (it == 0) ? 10'h005 : 10'($urandom_range(0, 1022));
      d = (it == 0) ? 32'h1234_5678 : $urandom;
      wr_q.delete();
      txq.delete();
      send_write(a, d);
      wait_tx(1, ok);
      exp_mem[a] = d;
      written.push_back(a);
      r = (txq.size() > 0) ? txq[0] : 8'hxx;
      w = (wr_q.size() > 0) ? wr_q[0] : 46'h0;
      checks++; if (!ok || txq.size() != 1 || r !== 8'h4B) begin
        failures++; $display("FAIL write_ack: got %h (n=%0d) want 4b", r, txq.size()); end
      checks++; if (wr_q.size() != 1) begin
        failures++; $display("FAIL write_count: got %0d want 1", wr_q.size()); end
      checks++; if (w[45:42] !== 4'hF) begin
        failures++; $display("FAIL write_we: got %h want f", w[45:42]); end
      checks++; if (w[41:32] !== a) begin
        failures++; $display("FAIL write_addr: got %h want %h", w[41:32], a); end
      checks++; if (w[31:0] !== d) begin
        failures++; $display("FAIL write_data: got %h want %h", w[31:0], d); end
      checks++; if (con_addr !== a || con_in !== d || busy !== 1'b0) begin
        failures++; $display("FAIL write_hold: got %h/%h/%b want %h/%h/0", con_addr, con_in, busy, a, d); end
    end
  endtask

  task automatic test_read();
    for (int it = 0; it < 4; it++) begin
      logic [9:0]  a;
      logic [31:0] word;
      logic [7:0]  r;
      bit ok;
      a = (it == 0) ? 10'h3FF : written[$urandom_range(0, written.size() - 1)];
      word = exp_mem[a];
      txq.delete();
      wr_q.delete();
      send_byte(8'h52, 0);
      send_byte((it == 0) ? 8'h03 : {6'($urandom), a[9:8]}, 0);
      send_byte(a[7:0], 0);
      wait_tx(4, ok);
      checks++; if (!ok || txq.size() != 4) begin
        failures++; $display("FAIL read_len: got %0d want 4", txq.size()); end
      for (int i = 0; i < 4; i++) begin
        r = (txq.size() > i) ? txq[i] : 8'hxx;
        checks++; if (r !== 8'(word >> (8 * i))) begin
          failures++; $display("FAIL read_byte%0d: got %h want %h", i, r, 8'(word >> (8 * i))); end
      end
      checks++; if (busy !== 1'b0 || wr_q.size() != 0 || tx_bad != 0) begin
        failures++; $display("FAIL read_after: busy %b writes %0d badframes %0d want 0/0/0",
                             busy, wr_q.size(), tx_bad); end
    end
  endtask

  task automatic test_unknown();
    for (int it = 0; it < 4; it++) begin
      logic [7:0] c;
      logic [7:0] r;
      bit ok;
      c = (it == 0) ? 8'h41 : 8'($urandom);
      if (c == 8'h57 || c == 8'h52) c = 8'h00;
      txq.delete();
      wr_q.delete();
      send_byte(c, 0);
      wait_tx(1, ok);
      r = (txq.size() > 0) ? txq[0] : 8'hxx;
      checks++; if (!ok || r !== 8'h3F) begin
        failures++; $display("FAIL unknown_nak: cmd %h got %h want 3f", c, r); end
      checks++; if (wr_q.size() != 0 || busy !== 1'b0) begin
        failures++; $display("FAIL unknown_state: writes %0d busy %b want 0/0", wr_q.size(), busy); end
    end
  endtask

  task automatic test_timeout();
    logic [9:0]  a;
    logic [31:0] d;
    logic [45:0] w;
    bit ok;
    txq.delete();
    wr_q.delete();
    err_cnt = 0;
    send_byte(8'h57, 0);
    send_byte(8'h00, 0);
    repeat (TO - 100) @(negedge CLK);
    checks++; if (err_cnt != 0 || busy !== 1'b1) begin
      failures++; $display("FAIL timeout_early: err %0d busy %b want 0/1", err_cnt, busy); end
    repeat (200) @(negedge CLK);
    checks++; if (err_cnt != 1) begin
      failures++; $display("FAIL timeout_err: got %0d pulses want 1", err_cnt); end
    checks++; if (busy !== 1'b0 || txq.size() != 0 || wr_q.size() != 0) begin
      failures++; $display("FAIL timeout_idle: busy %b tx %0d writes %0d want 0/0/0",
                           busy, txq.size(), wr_q.size()); end
    a = 10'($urandom_range(0, 1022));
    d = $urandom;
    send_write(a, d);
    wait_tx(1, ok);
    exp_mem[a] = d;
    written.push_back(a);
    w = (wr_q.size() > 0) ? wr_q[0] : 46'h0;
    checks++; if (!ok || wr_q.size() != 1 || w !== {4'hF, a, d}) begin
      failures++; $display("FAIL timeout_recover: got %h (n=%0d) want %h", w, wr_q.size(), {4'hF, a, d}); end
  endtask

  task automatic test_bad_frame(input int kind);
    logic [9:0]  a;
    logic [31:0] d;
    logic [45:0] w;
    bit ok;
    txq.delete();
    wr_q.delete();
    err_cnt = 0;
    send_byte(8'h57, 0);
    send_byte(8'h01, 0);
    send_byte(8'h23, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    send_byte(8'hCC, kind);
    send_byte(8'hDD, 0);
    repeat (40 * CPB) @(negedge CLK);
    checks++; if (err_cnt != 1) begin
      failures++; $display("FAIL badframe%0d_err: got %0d pulses want 1", kind, err_cnt); end
    checks++; if (wr_q.size() != 0 || busy !== 1'b0) begin
      failures++; $display("FAIL badframe%0d_state: writes %0d busy %b want 0/0", kind, wr_q.size(), busy); end
    checks++; if (txq.size() != 1 || txq[0] !== 8'h3F) begin
      failures++; $display("FAIL badframe%0d_tx: got %0d bytes want one 3f", kind, txq.size()); end
    repeat (20 * CPB) @(negedge CLK);
    txq.delete();
    wr_q.delete();
    a = 10'($urandom_range(0, 1022));
    d = $urandom;
    send_write(a, d);
    wait_tx(1, ok);
    exp_mem[a] = d;
    written.push_back(a);
    w = (wr_q.size() > 0) ? wr_q[0] : 46'h0;
    checks++; if (!ok || wr_q.size() != 1 || w !== {4'hF, a, d}) begin
      failures++; $display("FAIL badframe%0d_recover: got %h want %h", kind, w, {4'hF, a, d}); end
  endtask

  task automatic test_reset_mid();
    txq.delete();
    wr_q.delete();
    send_byte(8'h57, 0);
    send_byte(8'h02, 0);
    send_byte(8'h9C, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    rx = 1'b0;
    repeat (3 * CPB) @(negedge CLK);
    nrst = 1'b0;
    rx   = 1'b1;
    repeat (2) @(negedge CLK);
    checks++; if (con_addr !== 10'h0 || con_in !== 32'h0) begin
      failures++; $display("FAIL resetmid_regs: got %h/%h want 0/0", con_addr, con_in); end
    checks++; if (tx !== 1'b1 || busy !== 1'b0 || err !== 1'b0 || con_write !== 4'h0) begin
      failures++; $display("FAIL resetmid_outs: tx %b busy %b err %b we %h want 1/0/0/0",
                           tx, busy, err, con_write); end
    nrst = 1'b1;
    repeat (60 * CPB) @(negedge CLK);
    checks++; if (wr_q.size() != 0 || busy !== 1'b0 || txq.size() != 0) begin
      failures++; $display("FAIL resetmid_after: writes %0d busy %b tx %0d want 0/0/0",
                           wr_q.size(), busy, txq.size()); end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i]     = $urandom;
      exp_mem[i] = mem[i];
    end
    mem[1023]     = 32'hDEAD_BEEF;
    exp_mem[1023] = 32'hDEAD_BEEF;
    test_reset();
    test_write();
    test_read();
    test_unknown();
    test_timeout();
    test_bad_frame(1);
`ifdef UART_PARITY_EN
    test_bad_frame(2);
`endif
    test_read();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
